fsk_tone_generator: RTL

Transmit-side counterpart of the frequency analyzer chain. It converts a stream of 1-bit symbols into a frequency-shift-keyed square wave: FREQUENCY0 for symbol 0, FREQUENCY1 for symbol 1. The tone is also embedded into a synthetic 8-bit pixel stream at a fixed pixel index, so the pixel sampler and the three frequency analyzers can be driven on-chip for loopback and bring-up without the image sensor.

---
 rtl/fsk_tone_generator.sv | 113 +++++++++++
 1 files changed

// File: rtl/fsk_tone_generator.sv
// fsk_tone_generator: FSK square-wave transmitter that also embeds the tone in a synthetic pixel stream.
// Define FSK_UNDERRUN_COUNT_EN to build the saturating underrun counter; otherwise underrun_count reads 0.
module fsk_tone_generator #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int FREQUENCY0 = 9000,
  parameter int FREQUENCY1 = 11000,
  parameter int SYMBOL_PERIODS = 16,
  parameter int PIXEL_INDEX = 15,
  parameter int LINE_PIXELS = 1024,
  parameter int PIXEL_DIVIDER = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        symbol_data,
  input  logic        symbol_valid,
  output logic        symbol_ready,
  output logic        tone,
  output logic        busy,
  output logic [7:0]  data,
  output logic        pixel_strobe,
  output logic [15:0] underrun_count
);
  localparam logic [23:0] HP0 = 24'(CLOCK_FREQUENCY / (2 * FREQUENCY0));
  localparam logic [23:0] HP1 = 24'(CLOCK_FREQUENCY / (2 * FREQUENCY1));
  localparam logic [15:0] LAST_PERIOD = 16'(SYMBOL_PERIODS - 1);
  localparam int DW = $clog2(PIXEL_DIVIDER);
  localparam int PW = $clog2(LINE_PIXELS);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIXEL_DIVIDER - 1);
  localparam logic [PW-1:0] PIX_SLOT = PW'(PIXEL_INDEX);
  typedef enum logic {IDLE, TONE} state_t;
  state_t state, state_next;
  logic active, buf_full, buf_sym, tone_r;
  logic [23:0] half_cnt, hp;
  logic [15:0] per_cnt;
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] pix_cnt;
  logic accept, wrap, sym_end, chain, start, next_sym, div_wrap;
  assign symbol_ready = enable & ~reset & ~buf_full;
  assign busy = state == TONE;
  assign tone = tone_r;
  always_comb begin
    accept = symbol_valid & symbol_ready;
    hp = active ? HP1 : HP0;
    wrap = state == TONE && half_cnt == hp - 24'd1;
    // the symbol ends where the last low half would wrap back high
    sym_end = wrap && !tone_r && per_cnt == LAST_PERIOD;
    chain = sym_end && (buf_full || accept);
    start = state == IDLE && (buf_full || accept);
    next_sym = buf_full ? buf_sym : symbol_data;
    div_wrap = enable && div_cnt == DIV_LAST;
    state_next = start ? TONE : (sym_end && !chain) ? IDLE : state;
  end
  always_ff @(posedge clock) state <= (reset || !enable) ? IDLE : state_next;
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      tone_r <= 1'b0;
      half_cnt <= '0;
      per_cnt <= '0;
      buf_full <= 1'b0;
      buf_sym <= 1'b0;
      active <= 1'b0;
    end else begin
      if (start || chain) begin
        active <= next_sym;
        tone_r <= 1'b1;
        half_cnt <= '0;
        per_cnt <= '0;
      end else if (sym_end) begin
        tone_r <= 1'b0;
        half_cnt <= '0;
        per_cnt <= '0;
      end else if (wrap) begin
        tone_r <= ~tone_r;
        half_cnt <= '0;
        per_cnt <= per_cnt + {15'd0, ~tone_r};
      end else if (state == TONE) begin
        half_cnt <= half_cnt + 24'd1;
      end
      if (start || chain) begin
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_full <= 1'b1;
        buf_sym <= symbol_data;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      pix_cnt <= '0;
      pixel_strobe <= 1'b0;
      data <= 8'h00;
    end else begin
      if (enable) div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      pixel_strobe <= div_wrap;
      if (div_wrap) begin
        pix_cnt <= pix_cnt + 1'b1;
        data <= pix_cnt == PIX_SLOT ? {tone_r, 7'd0} : 8'h00;
      end
    end
  end
`ifdef FSK_UNDERRUN_COUNT_EN
  logic [15:0] ur_cnt;
  always_ff @(posedge clock) begin
    if (reset) ur_cnt <= '0;
    else if (enable && sym_end && !chain && ur_cnt != 16'hFFFF) ur_cnt <= ur_cnt + 16'd1;
  end
  assign underrun_count = ur_cnt;
`else
  assign underrun_count = 16'h0000;
`endif
endmodule
